// File: rtl/pdm_dac_multi_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel PDM output stage.
// Helpers work on a wide signed type; callers keep only the bits they need.
package pdm_pkg;

    localparam int ORDER_1 = 1;
    localparam int ORDER_2 = 2;
    localparam int CALC_W  = 64;

    typedef logic signed [CALC_W-1:0] calc_t;

    // Feedback is +/- half of the sample range, selected by the last output bit.
    function automatic calc_t fb_value(input logic b, input int data_w);
        calc_t mag;
        mag = calc_t'(1) <<< (data_w - 1);
        return b ? mag : -mag;
    endfunction

    // Add two values, then clamp the sum to the signed range of 'width' bits.
    function automatic calc_t sat_add(input calc_t a, input calc_t b, input int width);
        calc_t sum;
        calc_t hi;
        calc_t lo;
        sum = a + b;
        hi  = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        lo  = -(calc_t'(1) <<< (width - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pdm_mod_ch.sv
// One channel of the delta-sigma modulator: saturating integrators and a
// registered output bit, advanced only on tick_i and cleared while en_i is low.
module pdm_mod_ch
    import pdm_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ORDER  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic                     tick_i,
    input  logic signed [DATA_W-1:0] x_i,
    output logic                     pdm_o
);

    localparam int I1_W = DATA_W + 2;
    localparam int I2_W = DATA_W + 4;

    logic signed [I1_W-1:0] i1_q, i1_d;
    logic signed [I2_W-1:0] i2_q, i2_d;
    logic                   pdm_q, pdm_d;
    calc_t                  x_w, i1_w, i2_w, fb, s1, s2;

    always_comb begin
        x_w   = calc_t'(x_i);
        i1_w  = calc_t'(i1_q);
        i2_w  = calc_t'(i2_q);
        fb    = fb_value(pdm_q, DATA_W);
        s1    = sat_add(i1_w, x_w - fb, I1_W);
        s2    = sat_add(i2_w, s1 - fb, I2_W);
        i1_d  = i1_q;
        i2_d  = i2_q;
        pdm_d = pdm_q;
        if (!en_i) begin
            i1_d  = '0;
            i2_d  = '0;
            pdm_d = 1'b0;
        end else if (tick_i) begin
            // The second integrator is kept running in first-order builds; it just never drives the bit.
            i1_d  = s1[I1_W-1:0];
            i2_d  = s2[I2_W-1:0];
            pdm_d = (ORDER == ORDER_2) ? (s2 >= calc_t'(0)) : (s1 >= calc_t'(0));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            i1_q  <= '0;
            i2_q  <= '0;
            pdm_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm_o = pdm_q;

endmodule

// File: rtl/pdm_dac_multi.sv
// Multi-channel PDM output stage: tick divider, double-buffered sample path
// and one modulator per channel.
module pdm_dac_multi
    import pdm_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int NUM_CH = 2,
    parameter int ORDER  = 2,
    parameter int DIV_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     mute_i,
    input  logic [DIV_W-1:0]         div_i,
    input  logic [NUM_CH*DATA_W-1:0] sample_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    output logic                     underrun_o,
    output logic [NUM_CH-1:0]        pdm_o
);

    if ((ORDER != ORDER_1 && ORDER != ORDER_2) || DATA_W < 4 || NUM_CH < 1) begin : g_bad_param
        $error("pdm_dac_multi: ORDER must be 1 or 2, DATA_W >= 4, NUM_CH >= 1");
    end

    logic [DIV_W-1:0]         cnt_q, cnt_d;
    logic [NUM_CH*DATA_W-1:0] stg_q, stg_d;
    logic [NUM_CH*DATA_W-1:0] act_q, act_d;
    logic                     stg_full_q, stg_full_d;
    logic                     underrun_q, underrun_d;
    logic                     tick;
    logic                     accept;

    // Handshake: a sample transfers on any edge where sample_valid_i and
    // sample_ready_o are both high; ready depends only on the staging flag.
    always_comb begin
        tick       = enable_i && (cnt_q >= div_i);
        accept     = sample_valid_i && !stg_full_q;
        cnt_d      = '0;
        stg_d      = stg_q;
        act_d      = act_q;
        stg_full_d = stg_full_q;
        underrun_d = tick && !stg_full_q;
        if (enable_i && !tick) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // Accept and consume are exclusive: one needs staging empty, the other full.
        if (tick && stg_full_q) begin
            act_d      = stg_q;
            stg_full_d = 1'b0;
        end
        if (accept) begin
            stg_d      = sample_i;
            stg_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            stg_q      <= '0;
            act_q      <= '0;
            stg_full_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            stg_q      <= stg_d;
            act_q      <= act_d;
            stg_full_q <= stg_full_d;
            underrun_q <= underrun_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_W-1:0] x_c;
        assign x_c = mute_i ? '0 : act_q[c*DATA_W +: DATA_W];

        pdm_mod_ch #(
            .DATA_W(DATA_W),
            .ORDER (ORDER)
        ) u_mod (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .en_i  (enable_i),
            .tick_i(tick),
            .x_i   (x_c),
            .pdm_o (pdm_o[c])
        );
    end

    assign sample_ready_o = !stg_full_q;
    assign underrun_o     = underrun_q;

endmodule

// File: tb/tb_pdm_dac_multi.sv
// Bench for pdm_dac_multi: a first-order and a second-order instance share all
// inputs; density rows come from a table, timing corners from short sequences.
module tb_pdm_dac_multi;

    localparam int DATA_W = 14;
    localparam int NUM_CH = 2;
    localparam int DIV_W  = 8;
    localparam int SW     = NUM_CH * DATA_W;

    typedef struct {
        string      name;
        int         dut;
        int         s0;
        int         s1;
        logic [7:0] div;
        logic       mute;
        int         ticks;
        int         skip0;
        int         skip1;
        int         lo0;
        int         hi0;
        int         lo1;
        int         hi1;
    } row_t;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              enable = 1'b0;
    logic              mute   = 1'b0;
    logic [DIV_W-1:0]  div    = '0;
    logic [SW-1:0]     sample = '0;
    logic              valid  = 1'b0;
    logic              ready1, ready2, ur1, ur2;
    logic [NUM_CH-1:0] pdm1, pdm2;

    int total = 0;
    int bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    pdm_dac_multi #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ORDER(1), .DIV_W(DIV_W)) u_o1 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mute_i(mute), .div_i(div),
        .sample_i(sample), .sample_valid_i(valid), .sample_ready_o(ready1),
        .underrun_o(ur1), .pdm_o(pdm1)
    );

    pdm_dac_multi #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .ORDER(2), .DIV_W(DIV_W)) u_o2 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mute_i(mute), .div_i(div),
        .sample_i(sample), .sample_valid_i(valid), .sample_ready_o(ready2),
        .underrun_o(ur2), .pdm_o(pdm2)
    );

    // scoreboard helpers
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        mute   = 1'b0;
        valid  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic stage(input int s0, input int s1, input string name);
        sample = {DATA_W'(s1), DATA_W'(s0)};
        valid  = 1'b1;
        step();
        valid  = 1'b0;
        chk($sformatf("%s_ready_after_accept", name), int'(ready1) + int'(ready2), 0);
    endtask

    // Zero input from a cleared modulator at div=0: hand-derived bit patterns.
    task automatic zero_seq(input string name);
        logic [7:0] e1;
        logic [7:0] e2;
        logic [1:0] e;
        logic [1:0] exp_q[$];
        e1 = 8'b1010_1011;
        e2 = 8'b1100_1011;
        for (int t = 0; t < 8; t++) exp_q.push_back({e2[t], e1[t]});
        enable = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            e = exp_q.pop_front();
            chk($sformatf("%s_o1_t%0d", name, t), int'(pdm1), e[0] ? 3 : 0);
            chk($sformatf("%s_o2_t%0d", name, t), int'(pdm2), e[1] ? 3 : 0);
            chk($sformatf("%s_ur_t%0d", name, t), int'(ur2), (t >= 2) ? 1 : 0);
        end
    endtask

    task automatic run_row(input row_t r);
        int         ones0, ones1, wrong, k, per;
        logic [1:0] p;
        logic       u;
        do_reset();
        div  = r.div;
        mute = r.mute;
        stage(r.s0, r.s1, r.name);
        per   = int'(r.div) + 1;
        ones0 = 0;
        ones1 = 0;
        wrong = 0;
        k     = 0;
        enable = 1'b1;
        for (int cyc = 1; cyc <= r.ticks * per; cyc++) begin
            step();
            p = (r.dut == 1) ? pdm1 : pdm2;
            u = (r.dut == 1) ? ur1 : ur2;
            if (cyc % per == 0) begin
                k++;
                if (u != (k >= 2)) wrong++;
                if (k > r.skip0 && p[0]) ones0++;
                if (k > r.skip1 && p[1]) ones1++;
            end else if (u != 1'b0) begin
                wrong++;
            end
        end
        enable = 1'b0;
        mute   = 1'b0;
        chk($sformatf("%s_tick_timing", r.name), wrong, 0);
        chk_rng($sformatf("%s_ones_ch0", r.name), ones0, r.lo0, r.hi0);
        chk_rng($sformatf("%s_ones_ch1", r.name), ones1, r.lo1, r.hi1);
    endtask

    initial begin
        row_t       rows[4];
        int         n_acc, wrong_r, wrong_u, k;
        logic       prev_ready, exp_u;
        logic [3:0] e_ur, e_b0, e_o1c1;

        rows[0] = '{"zero_o1",   1,    0,     0, 8'd0, 1'b0,  1024, 0, 0,  510,   514,  510,  514};
        rows[1] = '{"dc_o2",     2, 4096, -4096, 8'd3, 1'b0,  4096, 0, 0, 3068,  3076, 1020, 1028};
        rows[2] = '{"full_o2",   2, 8191, -8192, 8'd0, 1'b0, 10000, 0, 8, 9990, 10000,    0,    0};
        rows[3] = '{"mute_o2",   2, 8191,  8191, 8'd0, 1'b1,  1024, 0, 0,  510,   514,  510,  514};

        // reset with valid held high: nothing may be captured
        rst_n  = 1'b0;
        valid  = 1'b1;
        sample = {DATA_W'(-8192), DATA_W'(-8192)};
        repeat (3) step();
        rst_n = 1'b1;
        valid = 1'b0;
        chk("rst_ready", int'(ready1) + int'(ready2), 2);
        chk("rst_pdm", int'(pdm1 | pdm2), 0);
        chk("rst_underrun", int'(ur1) + int'(ur2), 0);
        step();
        chk("rst_ready_after_release", int'(ready1) + int'(ready2), 2);

        div = 8'd0;
        stage(0, 0, "post_reset");
        zero_seq("post_reset");

        // disable mid-stream while a new sample is offered
        enable = 1'b0;
        sample = '0;
        valid  = 1'b1;
        step();
        valid = 1'b0;
        chk("dis_pdm_o1", int'(pdm1), 0);
        chk("dis_pdm_o2", int'(pdm2), 0);
        chk("dis_ready", int'(ready1) + int'(ready2), 0);
        step();
        step();
        chk("dis_no_underrun", int'(ur1) + int'(ur2), 0);
        chk("dis_ready_held", int'(ready1) + int'(ready2), 0);
        zero_seq("reenable");

        for (int i = 0; i < 4; i++) run_row(rows[i]);

        // back-to-back valid at div=7
        do_reset();
        div        = 8'd7;
        enable     = 1'b1;
        valid      = 1'b1;
        sample     = '0;
        prev_ready = 1'b1;
        n_acc      = 0;
        wrong_r    = 0;
        wrong_u    = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (prev_ready) n_acc++;
            prev_ready = ready2;
            if (ready2 != (j % 8 == 0)) wrong_r++;
            if (ur2) wrong_u++;
            if (ready2) sample = sample + SW'(1);
        end
        chk("hs_ready_pattern", wrong_r, 0);
        chk("hs_no_underrun", wrong_u, 0);
        chk("hs_accepts", n_acc, 5);

        // valid dropped: underrun on every tick, one cycle wide
        valid   = 1'b0;
        wrong_r = 0;
        wrong_u = 0;
        for (int j = 41; j <= 80; j++) begin
            step();
            exp_u = (j % 8 == 0) && (j >= 48);
            if (!ready2) wrong_r++;
            if (ur2 != exp_u) wrong_u++;
        end
        chk("ur_ready_high", wrong_r, 0);
        chk("ur_pulse_pattern", wrong_u, 0);

        // accept landing on a tick edge: the value drives the modulator two ticks later
        do_reset();
        div    = 8'd7;
        enable = 1'b1;
        sample = {DATA_W'(0), DATA_W'(-8192)};
        e_ur   = 4'b1101;
        e_b0   = 4'b0011;
        e_o1c1 = 4'b1011;
        for (int j = 1; j <= 32; j++) begin
            if (j == 8) valid = 1'b1;
            step();
            if (j == 8) valid = 1'b0;
            if (j % 8 == 0) begin
                k = j / 8;
                chk($sformatf("co_ur_k%0d", k), int'(ur2), int'(e_ur[k-1]));
                chk($sformatf("co_o1_ch0_k%0d", k), int'(pdm1[0]), int'(e_b0[k-1]));
                chk($sformatf("co_o2_ch0_k%0d", k), int'(pdm2[0]), int'(e_b0[k-1]));
                chk($sformatf("co_o1_ch1_k%0d", k), int'(pdm1[1]), int'(e_o1c1[k-1]));
            end
            if (j == 8)  chk("co_ready_after_accept", int'(ready2), 0);
            if (j == 9)  chk("co_ur_one_cycle", int'(ur2), 0);
            if (j == 16) chk("co_ready_after_consume", int'(ready2), 1);
        end
        enable = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
